// File: rtl/pll_lmmi_pkg.sv
// Shared types and widths for the PLL LMMI arbiter slice.
package pll_lmmi_pkg;
  localparam int unsigned LMMI_OFFSET_W = 7;
  localparam int unsigned LMMI_DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_grant only moves on a tie so a lone requester
// never disturbs the alternation order of contended grants.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any,
  output logic       grant
);
  logic last_grant;

  always_comb begin
    any   = |req;
    grant = (req == 2'b11) ? ~last_grant : req[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (take && (req == 2'b11)) begin
      last_grant <= grant;
    end
  end
endmodule

// File: rtl/pll_lmmi_arbiter.sv
// Shares the PLL LMMI configuration port between two requesters with round-robin
// arbitration, read-data return and a per-transaction timeout.
module pll_lmmi_arbiter
  import pll_lmmi_pkg::*;
#(
  parameter int unsigned OFFSET_W       = LMMI_OFFSET_W,
  parameter int unsigned DATA_W         = LMMI_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic                LMMICLK,
  input  logic                LMMIRESET_N,
  input  logic                R0_REQUEST,
  input  logic                R0_WRRD_N,
  input  logic [OFFSET_W-1:0] R0_OFFSET,
  input  logic [DATA_W-1:0]   R0_WDATA,
  output logic                R0_READY,
  output logic                R0_RDATAVALID,
  output logic [DATA_W-1:0]   R0_RDATA,
  output logic                R0_ERR,
  input  logic                R1_REQUEST,
  input  logic                R1_WRRD_N,
  input  logic [OFFSET_W-1:0] R1_OFFSET,
  input  logic [DATA_W-1:0]   R1_WDATA,
  output logic                R1_READY,
  output logic                R1_RDATAVALID,
  output logic [DATA_W-1:0]   R1_RDATA,
  output logic                R1_ERR,
  output logic                LMMIREQUEST,
  output logic                LMMIWRRD_N,
  output logic [OFFSET_W-1:0] LMMIOFFSET,
  output logic [DATA_W-1:0]   LMMIWDATA,
  input  logic                LMMIREADY,
  input  logic                LMMIRDATAVALID,
  input  logic [DATA_W-1:0]   LMMIRDATA,
  output logic                BUSY,
  output logic                TO_STICKY,
  input  logic                CLR_TO
);
  state_t              state;
  logic                gnt;
  logic [TO_W-1:0]     cnt;
  logic                lmmi_req;
  logic                lmmi_wrrd;
  logic [OFFSET_W-1:0] lmmi_off;
  logic [DATA_W-1:0]   lmmi_wd;
  logic [1:0]          ready;
  logic [1:0]          rdv;
  logic [1:0]          err;
  logic [DATA_W-1:0]   rdata0;
  logic [DATA_W-1:0]   rdata1;
  logic                busy;
  logic                to_sticky;

  logic                arb_any;
  logic                arb_grant;
  logic                arb_take;
  logic                sel_wrrd;
  logic [OFFSET_W-1:0] sel_off;
  logic [DATA_W-1:0]   sel_wd;
  logic                timeout;

  rr_arb2 u_arb (
    .clk   (LMMICLK),
    .rst_n (LMMIRESET_N),
    .req   ({R1_REQUEST, R0_REQUEST}),
    .take  (arb_take),
    .any   (arb_any),
    .grant (arb_grant)
  );

  always_comb begin
    arb_take = (state == IDLE) && arb_any;
    sel_wrrd = arb_grant ? R1_WRRD_N : R0_WRRD_N;
    sel_off  = arb_grant ? R1_OFFSET : R0_OFFSET;
    sel_wd   = arb_grant ? R1_WDATA  : R0_WDATA;
    timeout  = (cnt == TO_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge LMMICLK or negedge LMMIRESET_N) begin
    if (!LMMIRESET_N) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      cnt       <= '0;
      lmmi_req  <= 1'b0;
      lmmi_wrrd <= 1'b0;
      lmmi_off  <= '0;
      lmmi_wd   <= '0;
      ready     <= '0;
      rdv       <= '0;
      err       <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      to_sticky <= 1'b0;
    end else begin
      // Completion pulses are raised on the transition into DONE and last one cycle.
      ready <= '0;
      rdv   <= '0;
      err   <= '0;
      if (CLR_TO) to_sticky <= 1'b0;

      unique case (state)
        IDLE: begin
          if (arb_any) begin
            gnt       <= arb_grant;
            lmmi_wrrd <= sel_wrrd;
            lmmi_off  <= sel_off;
            lmmi_wd   <= sel_wd;
            lmmi_req  <= 1'b1;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (LMMIREADY) begin
            lmmi_req <= 1'b0;
            cnt      <= '0;
            if (lmmi_wrrd) begin
              ready[gnt] <= 1'b1;
              state      <= DONE;
            end else begin
              state <= WAIT_RD;
            end
          end else if (timeout) begin
            lmmi_req   <= 1'b0;
            ready[gnt] <= 1'b1;
            err[gnt]   <= 1'b1;
            to_sticky  <= 1'b1;
            if (gnt) rdata1 <= '0;
            else     rdata0 <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        WAIT_RD: begin
          if (LMMIRDATAVALID) begin
            ready[gnt] <= 1'b1;
            rdv[gnt]   <= 1'b1;
            if (gnt) rdata1 <= LMMIRDATA;
            else     rdata0 <= LMMIRDATA;
            state      <= DONE;
          end else if (timeout) begin
            ready[gnt] <= 1'b1;
            err[gnt]   <= 1'b1;
            to_sticky  <= 1'b1;
            if (gnt) rdata1 <= '0;
            else     rdata0 <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign R0_READY      = ready[0];
  assign R1_READY      = ready[1];
  assign R0_RDATAVALID = rdv[0];
  assign R1_RDATAVALID = rdv[1];
  assign R0_ERR        = err[0];
  assign R1_ERR        = err[1];
  assign R0_RDATA      = rdata0;
  assign R1_RDATA      = rdata1;
  assign LMMIREQUEST   = lmmi_req;
  assign LMMIWRRD_N    = lmmi_wrrd;
  assign LMMIOFFSET    = lmmi_off;
  assign LMMIWDATA     = lmmi_wd;
  assign BUSY          = busy;
  assign TO_STICKY     = to_sticky;
endmodule

// File: tb/tb_pll_lmmi_arbiter.sv
// Scoreboard bench for pll_lmmi_arbiter: a PLL responder, auto-dropping requesters,
// and a monitor popping expected completions whenever a READY pulse appears.
module tb_pll_lmmi_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       R0_REQUEST = 1'b0, R0_WRRD_N = 1'b0;
  logic [6:0] R0_OFFSET = '0;
  logic [7:0] R0_WDATA = '0;
  logic       R0_READY, R0_RDATAVALID, R0_ERR;
  logic [7:0] R0_RDATA;
  logic       R1_REQUEST = 1'b0, R1_WRRD_N = 1'b0;
  logic [6:0] R1_OFFSET = '0;
  logic [7:0] R1_WDATA = '0;
  logic       R1_READY, R1_RDATAVALID, R1_ERR;
  logic [7:0] R1_RDATA;
  logic       LMMIREQUEST, LMMIWRRD_N;
  logic [6:0] LMMIOFFSET;
  logic [7:0] LMMIWDATA;
  logic       LMMIREADY = 1'b0, LMMIRDATAVALID = 1'b0;
  logic [7:0] LMMIRDATA = '0;
  logic       BUSY, TO_STICKY;
  logic       CLR_TO = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic       rdv;
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // PLL responder knobs: negative values mean "never".
  int         pll_ready_after = 0;
  int         pll_rdv_after = 1;
  logic [7:0] pll_rdata = '0;
  int         pll_req_cnt = 0;
  int         pll_rdv_wait = 0;
  bit         pll_ready_done = 1'b0;

  pll_lmmi_arbiter #(
    .OFFSET_W       (7),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (8),
    .TO_W           (8)
  ) dut (
    .LMMICLK        (clk),
    .LMMIRESET_N    (rst_n),
    .R0_REQUEST     (R0_REQUEST),
    .R0_WRRD_N      (R0_WRRD_N),
    .R0_OFFSET      (R0_OFFSET),
    .R0_WDATA       (R0_WDATA),
    .R0_READY       (R0_READY),
    .R0_RDATAVALID  (R0_RDATAVALID),
    .R0_RDATA       (R0_RDATA),
    .R0_ERR         (R0_ERR),
    .R1_REQUEST     (R1_REQUEST),
    .R1_WRRD_N      (R1_WRRD_N),
    .R1_OFFSET      (R1_OFFSET),
    .R1_WDATA       (R1_WDATA),
    .R1_READY       (R1_READY),
    .R1_RDATAVALID  (R1_RDATAVALID),
    .R1_RDATA       (R1_RDATA),
    .R1_ERR         (R1_ERR),
    .LMMIREQUEST    (LMMIREQUEST),
    .LMMIWRRD_N     (LMMIWRRD_N),
    .LMMIOFFSET     (LMMIOFFSET),
    .LMMIWDATA      (LMMIWDATA),
    .LMMIREADY      (LMMIREADY),
    .LMMIRDATAVALID (LMMIRDATAVALID),
    .LMMIRDATA      (LMMIRDATA),
    .BUSY           (BUSY),
    .TO_STICKY      (TO_STICKY),
    .CLR_TO         (CLR_TO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PLL model: drives inputs on negedges, reads only DUT outputs.
  always @(negedge clk) begin
    LMMIREADY      = 1'b0;
    LMMIRDATAVALID = 1'b0;
    if (pll_rdv_wait > 0) begin
      pll_rdv_wait--;
      if (pll_rdv_wait == 0) begin
        LMMIRDATAVALID = 1'b1;
        LMMIRDATA      = pll_rdata;
      end
    end
    if (LMMIREQUEST && !pll_ready_done) begin
      if (pll_ready_after >= 0 && pll_req_cnt == pll_ready_after) begin
        LMMIREADY      = 1'b1;
        pll_ready_done = 1'b1;
        if (!LMMIWRRD_N && pll_rdv_after > 0) pll_rdv_wait = pll_rdv_after;
      end
      pll_req_cnt++;
    end
    if (!LMMIREQUEST) begin
      pll_req_cnt    = 0;
      pll_ready_done = 1'b0;
    end
  end

  // Requesters release REQUEST on seeing READY.
  always @(negedge clk) begin
    if (R0_READY) R0_REQUEST = 1'b0;
    if (R1_READY) R1_REQUEST = 1'b0;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (R0_READY || R1_READY) begin
      check("one_ready_at_a_time", {31'd0, R0_READY & R1_READY}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {31'd0, R1_READY}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("ready_id", R1_READY ? 32'd1 : 32'd0, mon_e.id);
        if (mon_e.id == 1) begin
          check("r1_rdatavalid", {31'd0, R1_RDATAVALID}, {31'd0, mon_e.rdv});
          check("r1_err", {31'd0, R1_ERR}, {31'd0, mon_e.err});
          if (mon_e.rdv || mon_e.err) check("r1_rdata", {24'd0, R1_RDATA}, {24'd0, mon_e.rdata});
        end else begin
          check("r0_rdatavalid", {31'd0, R0_RDATAVALID}, {31'd0, mon_e.rdv});
          check("r0_err", {31'd0, R0_ERR}, {31'd0, mon_e.err});
          if (mon_e.rdv || mon_e.err) check("r0_rdata", {24'd0, R0_RDATA}, {24'd0, mon_e.rdata});
        end
      end
    end else if (R0_RDATAVALID || R1_RDATAVALID || R0_ERR || R1_ERR) begin
      check("stray_pulse", {28'd0, R0_RDATAVALID, R1_RDATAVALID, R0_ERR, R1_ERR}, 32'd0);
    end
  end

  task automatic issue(input int id, input logic wr, input logic [6:0] off, input logic [7:0] wd);
    if (id == 0) begin
      R0_WRRD_N = wr; R0_OFFSET = off; R0_WDATA = wd; R0_REQUEST = 1'b1;
    end else begin
      R1_WRRD_N = wr; R1_OFFSET = off; R1_WDATA = wd; R1_REQUEST = 1'b1;
    end
  endtask

  task automatic expect_done(input int id, input logic rdv, input logic [7:0] rdata, input logic err);
    exp_t e;
    e.id = id; e.rdv = rdv; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((R0_REQUEST || R1_REQUEST || BUSY || exp_q.size() != 0) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, (n >= 100) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_lmmireq", {31'd0, LMMIREQUEST}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_ready", {30'd0, R1_READY, R0_READY}, 32'd0);
    check("rst_sticky", {31'd0, TO_STICKY}, 32'd0);
    check("rst_rdata", {16'd0, R1_RDATA, R0_RDATA}, 32'd0);
    rst_n = 1'b1;

    // 1: single write, PLL ready immediately
    pll_ready_after = 0;
    issue(0, 1'b1, 7'h12, 8'hA5);
    expect_done(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("t1_lmmireq_c1", {31'd0, LMMIREQUEST}, 32'd1);
    check("t1_offset_c1", {25'd0, LMMIOFFSET}, 32'h12);
    check("t1_wdata_c1", {24'd0, LMMIWDATA}, 32'hA5);
    check("t1_wrrd_c1", {31'd0, LMMIWRRD_N}, 32'd1);
    check("t1_busy_c1", {31'd0, BUSY}, 32'd1);
    check("t1_ready_c1", {31'd0, R0_READY}, 32'd0);
    @(negedge clk);
    check("t1_ready_c2", {31'd0, R0_READY}, 32'd1);
    check("t1_lmmireq_c2", {31'd0, LMMIREQUEST}, 32'd0);
    wait_idle("t1_idle");

    // 2: read, RDATAVALID three cycles after READY
    pll_ready_after = 0; pll_rdv_after = 3; pll_rdata = 8'h3C;
    issue(1, 1'b0, 7'h05, 8'h00);
    expect_done(1, 1'b1, 8'h3C, 1'b0);
    @(negedge clk);
    check("t2_wrrd_c1", {31'd0, LMMIWRRD_N}, 32'd0);
    check("t2_offset_c1", {25'd0, LMMIOFFSET}, 32'h05);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("t2_no_early_ready", {31'd0, R1_READY}, 32'd0);
    end
    @(negedge clk);
    check("t2_ready_c5", {31'd0, R1_READY}, 32'd1);
    check("t2_rdv_c5", {31'd0, R1_RDATAVALID}, 32'd1);
    wait_idle("t2_idle");
    repeat (3) @(negedge clk);
    check("t2_rdata_hold", {24'd0, R1_RDATA}, 32'h3C);

    // 3: ties alternate; a lone grant in between leaves the order alone
    pll_ready_after = 0; pll_rdv_after = 1;
    issue(0, 1'b1, 7'h20, 8'h11);
    issue(1, 1'b1, 7'h21, 8'h22);
    expect_done(0, 1'b0, 8'h00, 1'b0);
    expect_done(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("t3_tie1_offset", {25'd0, LMMIOFFSET}, 32'h20);
    wait_idle("t3_idle1");
    issue(0, 1'b1, 7'h30, 8'h33);
    issue(1, 1'b1, 7'h31, 8'h44);
    expect_done(1, 1'b0, 8'h00, 1'b0);
    expect_done(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("t3_tie2_offset", {25'd0, LMMIOFFSET}, 32'h31);
    check("t3_tie2_wdata", {24'd0, LMMIWDATA}, 32'h44);
    wait_idle("t3_idle2");

    // 4: LMMIREADY never arrives during a write
    pll_ready_after = -1;
    issue(0, 1'b1, 7'h40, 8'h77);
    expect_done(0, 1'b0, 8'h00, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t4_req_held", {31'd0, LMMIREQUEST}, 32'd1);
    end
    @(negedge clk);
    check("t4_req_drop", {31'd0, LMMIREQUEST}, 32'd0);
    check("t4_ready", {31'd0, R0_READY}, 32'd1);
    check("t4_err", {31'd0, R0_ERR}, 32'd1);
    check("t4_sticky", {31'd0, TO_STICKY}, 32'd1);
    wait_idle("t4_idle");
    check("t4_sticky_hold", {31'd0, TO_STICKY}, 32'd1);
    CLR_TO = 1'b1;
    @(negedge clk);
    CLR_TO = 1'b0;
    check("t4_sticky_clr", {31'd0, TO_STICKY}, 32'd0);

    // 5: good read, then a read whose data never comes back
    pll_ready_after = 0; pll_rdv_after = 1; pll_rdata = 8'h5A;
    issue(0, 1'b0, 7'h50, 8'h00);
    expect_done(0, 1'b1, 8'h5A, 1'b0);
    wait_idle("t5_idle1");
    check("t5_rdata_good", {24'd0, R0_RDATA}, 32'h5A);
    pll_rdv_after = -1;
    issue(0, 1'b0, 7'h51, 8'h00);
    expect_done(0, 1'b0, 8'h00, 1'b1);
    for (int c = 1; c <= 9; c++) @(negedge clk);
    check("t5_no_ready_c9", {31'd0, R0_READY}, 32'd0);
    @(negedge clk);
    check("t5_ready_c10", {31'd0, R0_READY}, 32'd1);
    check("t5_sticky", {31'd0, TO_STICKY}, 32'd1);
    wait_idle("t5_idle2");
    CLR_TO = 1'b1;
    @(negedge clk);
    CLR_TO = 1'b0;

    // 6: reset mid-ISSUE, then a tie goes to R0 again
    pll_ready_after = -1;
    issue(1, 1'b1, 7'h60, 8'h66);
    repeat (3) @(negedge clk);
    check("t6_issue_req", {31'd0, LMMIREQUEST}, 32'd1);
    #2;
    rst_n = 1'b0;
    R1_REQUEST = 1'b0;
    #1;
    check("t6_async_req", {31'd0, LMMIREQUEST}, 32'd0);
    check("t6_async_busy", {31'd0, BUSY}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pll_ready_after = 0; pll_rdv_after = 1;
    issue(0, 1'b1, 7'h70, 8'h01);
    issue(1, 1'b1, 7'h71, 8'h02);
    expect_done(0, 1'b0, 8'h00, 1'b0);
    expect_done(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("t6_tie_offset", {25'd0, LMMIOFFSET}, 32'h70);
    wait_idle("t6_idle");

    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
